// File: rtl/rc4_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rc4_sched_pkg : shared types and helpers for the RC4 key scheduler |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rc4_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    DRAIN     = 3'd2,
    FOUND     = 3'd3,
    EXHAUSTED = 3'd4
  } sched_state_t;

  localparam int KEY_W_DEFAULT = 22;
  localparam int MAX_CORES     = 16;

  function automatic logic [63:0] key_space(input int unsigned key_w);
    return 64'd1 << key_w;
  endfunction

  // Dones are zero-extended to MAX_CORES so one helper covers every core count.
  function automatic logic [4:0] popcount(input logic [MAX_CORES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_sched_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rc4_sched_pick : fixed-priority find-first-set (lowest index wins) |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rc4_sched_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             any_o,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    any_o    = |req_i;
    onehot_o = '0;
    idx_o    = '0;
    // Scan downward so the last hit written is the lowest set bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc4_search_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rc4_search_scheduler : shares the RC4 key space among decrypt cores |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rc4_search_scheduler
  import rc4_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = KEY_W_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [NUM_CORES-1:0]       core_done_i,
  input  logic [NUM_CORES-1:0]       core_valid_i,
  output logic [NUM_CORES-1:0]       core_start_o,
  output logic [NUM_CORES*KEY_W-1:0] core_key_o,
  output logic                       core_abort_o,
  output logic                       busy_o,
  output logic                       found_o,
  output logic                       exhausted_o,
  output logic [KEY_W-1:0]           key_found_o,
  output logic [KEY_W:0]             keys_tried_o
);

  localparam int             IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_W:0] KEY_SPACE = (KEY_W + 1)'(key_space(KEY_W));

  sched_state_t                         state_q, state_d;
  logic [KEY_W:0]                       next_key_q, next_key_d;
  logic [NUM_CORES-1:0]                 core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0][KEY_W-1:0]      core_key_q, core_key_d;
  logic [NUM_CORES-1:0]                 core_start_q, core_start_d;
  logic [KEY_W-1:0]                     key_found_q, key_found_d;
  logic                                 found_q, found_d;
  logic                                 exhausted_q, exhausted_d;
  logic [KEY_W:0]                       keys_tried_q, keys_tried_d;

  logic                                 searching;
  logic [NUM_CORES-1:0]                 qual_done;
  logic [NUM_CORES-1:0]                 qual_valid;
  logic [NUM_CORES-1:0]                 busy_left;
  logic [KEY_W+1:0]                     tried_sum;

  logic                                 idle_any;
  logic [NUM_CORES-1:0]                 idle_oh;
  logic [IDX_W-1:0]                     idle_idx;
  logic                                 valid_any;
  logic [NUM_CORES-1:0]                 unused_valid_oh;
  logic [IDX_W-1:0]                     valid_idx;

  assign searching  = (state_q == RUN) || (state_q == DRAIN);
  assign qual_done  = searching ? (core_done_i & core_busy_q) : '0;
  assign qual_valid = qual_done & core_valid_i;
  assign busy_left  = core_busy_q & ~qual_done;
  assign tried_sum  = {1'b0, keys_tried_q} + (KEY_W + 2)'(popcount(MAX_CORES'(qual_done)));

  // Idle selection uses the pre-completion busy vector, so a core freed this
  // cycle is only re-dispatched on the following cycle.
  rc4_sched_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_pick_idle (
    .req_i    (~core_busy_q),
    .any_o    (idle_any),
    .onehot_o (idle_oh),
    .idx_o    (idle_idx)
  );

  rc4_sched_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_pick_valid (
    .req_i    (qual_valid),
    .any_o    (valid_any),
    .onehot_o (unused_valid_oh),
    .idx_o    (valid_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      next_key_q   <= '0;
      core_busy_q  <= '0;
      core_key_q   <= '0;
      core_start_q <= '0;
      key_found_q  <= '0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      keys_tried_q <= '0;
    end else begin
      state_q      <= state_d;
      next_key_q   <= next_key_d;
      core_busy_q  <= core_busy_d;
      core_key_q   <= core_key_d;
      core_start_q <= core_start_d;
      key_found_q  <= key_found_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
      keys_tried_q <= keys_tried_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    core_busy_d  = core_busy_q;
    core_key_d   = core_key_q;
    core_start_d = '0;
    key_found_d  = key_found_q;
    found_d      = found_q;
    exhausted_d  = exhausted_q;
    keys_tried_d = keys_tried_q;

    case (state_q)
      IDLE, FOUND, EXHAUSTED: begin
        if (start_i) begin
          state_d      = RUN;
          next_key_d   = '0;
          core_busy_d  = '0;
          key_found_d  = '0;
          found_d      = 1'b0;
          exhausted_d  = 1'b0;
          keys_tried_d = '0;
        end
      end

      RUN, DRAIN: begin
        keys_tried_d = (tried_sum > {1'b0, KEY_SPACE}) ? KEY_SPACE : tried_sum[KEY_W:0];
        if (valid_any) begin
          // A hit beats both dispatch and exhaustion in the same cycle.
          state_d     = FOUND;
          found_d     = 1'b1;
          key_found_d = core_key_q[valid_idx];
          core_busy_d = '0;
        end else begin
          core_busy_d = busy_left;
          if (state_q == RUN && idle_any && next_key_q < KEY_SPACE) begin
            core_start_d         = idle_oh;
            core_key_d[idle_idx] = next_key_q[KEY_W-1:0];
            core_busy_d          = busy_left | idle_oh;
            next_key_d           = next_key_q + 1'b1;
            if (next_key_d == KEY_SPACE) begin
              state_d = DRAIN;
            end
          end else if (state_q == DRAIN && busy_left == '0) begin
            state_d     = EXHAUSTED;
            exhausted_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign core_start_o = core_start_q;
  assign core_key_o   = core_key_q;
  assign core_abort_o = (state_q == FOUND) || (state_q == EXHAUSTED);
  assign busy_o       = searching;
  assign found_o      = found_q;
  assign exhausted_o  = exhausted_q;
  assign key_found_o  = key_found_q;
  assign keys_tried_o = keys_tried_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_search_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rc4_search_scheduler : bench for a 4x22 and a 2x4 scheduler      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rc4_search_scheduler;

  // Abstract view of a search: flags plus plain integer bookkeeping.
  typedef struct packed {
    bit                active;
    bit                out_of_keys;
    bit                found;
    bit                exh;
    int                nxt;
    int                tried;
    int                kf;
    logic [15:0]       bsy;
    logic [15:0]       sv;
    logic [15:0][31:0] keys;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        b_start = 1'b0;
  logic [3:0]  b_done  = '0;
  logic [3:0]  b_valid = '0;
  logic [3:0]  b_cs;
  logic [87:0] b_key;
  logic        b_abort, b_busy, b_found, b_exh;
  logic [21:0] b_kf;
  logic [22:0] b_tried;

  logic        s_start = 1'b0;
  logic [1:0]  s_done  = '0;
  logic [1:0]  s_valid = '0;
  logic [1:0]  s_cs;
  logic [7:0]  s_key;
  logic        s_abort, s_busy, s_found, s_exh;
  logic [3:0]  s_kf;
  logic [4:0]  s_tried;

  rc4_search_scheduler #(.NUM_CORES(4), .KEY_W(22)) u_big (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .core_done_i(b_done),
    .core_valid_i(b_valid), .core_start_o(b_cs), .core_key_o(b_key),
    .core_abort_o(b_abort), .busy_o(b_busy), .found_o(b_found),
    .exhausted_o(b_exh), .key_found_o(b_kf), .keys_tried_o(b_tried)
  );

  rc4_search_scheduler #(.NUM_CORES(2), .KEY_W(4)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .core_done_i(s_done),
    .core_valid_i(s_valid), .core_start_o(s_cs), .core_key_o(s_key),
    .core_abort_o(s_abort), .busy_o(s_busy), .found_o(s_found),
    .exhausted_o(s_exh), .key_found_o(s_kf), .keys_tried_o(s_tried)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic model_t step(input model_t m, input int nc, input int kspace,
                                  input bit rst_n_v, input bit start,
                                  input logic [15:0] done, input logic [15:0] valid);
    model_t      n;
    logic [15:0] fin;
    int          winner;
    int          pick;
    if (!rst_n_v) return '0;
    n    = m;
    n.sv = '0;
    if (!m.active) begin
      if (start) begin
        n.active = 1; n.out_of_keys = 0; n.found = 0; n.exh = 0;
        n.nxt = 0; n.tried = 0; n.kf = 0; n.bsy = '0;
      end
      return n;
    end
    fin     = done & m.bsy;
    n.tried = m.tried + $countones(fin);
    if (n.tried > kspace) n.tried = kspace;
    winner = -1;
    for (int i = 0; i < nc; i++)
      if (fin[i] && valid[i] && winner < 0) winner = i;
    if (winner >= 0) begin
      n.found = 1; n.kf = m.keys[winner]; n.active = 0; n.bsy = '0; n.out_of_keys = 0;
      return n;
    end
    n.bsy = m.bsy & ~fin;
    if (!m.out_of_keys) begin
      pick = -1;
      for (int i = 0; i < nc; i++)
        if (!m.bsy[i] && pick < 0) pick = i;
      if (pick >= 0) begin
        n.keys[pick] = m.nxt;
        n.bsy[pick]  = 1'b1;
        n.sv[pick]   = 1'b1;
        n.nxt        = m.nxt + 1;
        if (n.nxt == kspace) n.out_of_keys = 1;
      end
    end else if (n.bsy == '0) begin
      n.exh = 1; n.active = 0; n.out_of_keys = 0;
    end
    return n;
  endfunction

  model_t mb = '0;
  model_t ms = '0;

  always @(posedge clk) begin
    mb <= step(mb, 4, 1 << 22, rst_n, b_start, 16'(b_done), 16'(b_valid));
    ms <= step(ms, 2, 16, rst_n, s_start, 16'(s_done), 16'(s_valid));
  end

  task automatic cmp_dut(input string tag, input model_t m, input int nc, input int kw,
                         input logic [15:0] cs, input logic [127:0] keys,
                         input bit abort, input bit busy, input bit found, input bit exh,
                         input longint kf, input longint tried);
    longint mask;
    mask = (longint'(1) << kw) - 1;
    check({tag, ".core_start"}, longint'(cs), longint'(m.sv));
    for (int i = 0; i < nc; i++)
      check($sformatf("%s.core_key%0d", tag, i),
            longint'(keys >> (i * kw)) & mask, longint'(m.keys[i]) & mask);
    check({tag, ".core_abort"}, longint'(abort), longint'(m.found | m.exh));
    check({tag, ".busy"},       longint'(busy),  longint'(m.active));
    check({tag, ".found"},      longint'(found), longint'(m.found));
    check({tag, ".exhausted"},  longint'(exh),   longint'(m.exh));
    check({tag, ".key_found"},  kf,              longint'(m.kf));
    check({tag, ".keys_tried"}, tried,           longint'(m.tried));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("big", mb, 4, 22, 16'(b_cs), 128'(b_key), b_abort, b_busy, b_found, b_exh,
              longint'(b_kf), longint'(b_tried));
      cmp_dut("small", ms, 2, 4, 16'(s_cs), 128'(s_key), s_abort, s_busy, s_found, s_exh,
              longint'(s_kf), longint'(s_tried));
    end
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    int ndisp;
    int idx;
    bit done_loop;

    repeat (3) nclk();
    cmp_en = 1'b1;
    check("reset.busy", longint'(b_busy), 0);
    check("reset.core_key", longint'(b_key[63:0]), 0);
    check("reset.abort", longint'(b_abort), 0);
    rst_n = 1'b1;

    // Basic dispatch: cores 0..3 launched with keys 0..3, then nothing.
    nclk(); b_start = 1'b1;
    nclk(); b_start = 1'b0;
    check("run.busy", longint'(b_busy), 1);
    check("run.no_early_start", longint'(b_cs), 0);
    nclk(); check("disp.c0", longint'(b_cs), 4'b0001);
    check("disp.key0", longint'(b_key[21:0]), 0);
    nclk(); check("disp.c1", longint'(b_cs), 4'b0010);
    nclk(); check("disp.c2", longint'(b_cs), 4'b0100);
    nclk(); check("disp.c3", longint'(b_cs), 4'b1000);
    check("disp.key3", longint'(b_key[87:66]), 3);

    // Recycle: core 2 finishes invalid, relaunched with key 4.
    nclk(); check("disp.no_fifth", longint'(b_cs), 0);
    b_done = 4'b0100;
    nclk(); b_done = 4'b0000;
    check("recycle.tried", longint'(b_tried), 1);
    check("recycle.same_cycle", longint'(b_cs), 0);
    nclk(); check("recycle.c2", longint'(b_cs), 4'b0100);
    check("recycle.key2", longint'(b_key[65:44]), 4);

    // Core 0 done twice in a row: the second pulse hits an idle core.
    b_done = 4'b0001;
    nclk(); check("spur.tried1", longint'(b_tried), 2);
    nclk(); b_done = 4'b0000;
    check("spur.c0", longint'(b_cs), 4'b0001);
    check("spur.key0", longint'(b_key[21:0]), 5);
    check("spur.tried2", longint'(b_tried), 2);

    // start while running must not restart the search.
    b_start = 1'b1;
    nclk(); b_start = 1'b0;
    nclk(); check("start_in_run.no_disp", longint'(b_cs), 0);
    check("start_in_run.tried", longint'(b_tried), 2);

    // Cores 1 and 3 (keys 1 and 3) both valid in one cycle: lowest index wins.
    b_done = 4'b1010; b_valid = 4'b1010;
    nclk(); b_done = 4'b0000; b_valid = 4'b0000;
    check("hit.found", longint'(b_found), 1);
    check("hit.key", longint'(b_kf), 1);
    check("hit.abort", longint'(b_abort), 1);
    check("hit.busy", longint'(b_busy), 0);
    nclk(); check("hit.no_disp", longint'(b_cs), 0);

    // Restart from FOUND: flags clear, key 0 dispatched again.
    b_start = 1'b1;
    nclk(); b_start = 1'b0;
    check("restart.found", longint'(b_found), 0);
    check("restart.abort", longint'(b_abort), 0);
    nclk(); check("restart.c0", longint'(b_cs), 4'b0001);
    check("restart.key0", longint'(b_key[21:0]), 0);

    // Reset with cores 0..2 busy, then late dones must be ignored.
    nclk(); nclk();
    rst_n = 1'b0;
    nclk(); rst_n = 1'b1;
    check("rst.busy", longint'(b_busy), 0);
    check("rst.key", longint'(b_key[63:0]), 0);
    check("rst.tried", longint'(b_tried), 0);
    b_done = 4'b0111; b_valid = 4'b0111;
    nclk(); b_done = 4'b0000; b_valid = 4'b0000;
    check("rst.late_found", longint'(b_found), 0);
    check("rst.late_tried", longint'(b_tried), 0);

    // Exhaustion on the 2-core, 4-bit instance with every attempt invalid.
    s_start = 1'b1;
    nclk(); s_start = 1'b0;
    ndisp     = 0;
    done_loop = 1'b0;
    for (int cyc = 0; cyc < 120 && !done_loop; cyc++) begin
      nclk();
      if (s_cs != 2'b00) begin
        idx = s_cs[0] ? 0 : 1;
        check("exh.key_order", longint'(s_key[idx*4 +: 4]), longint'(ndisp));
        ndisp++;
      end
      s_done = s_cs;
      if (s_exh) done_loop = 1'b1;
    end
    s_done = 2'b00;
    check("exh.reached", longint'(done_loop), 1);
    check("exh.dispatches", longint'(ndisp), 16);
    check("exh.tried", longint'(s_tried), 16);
    check("exh.abort", longint'(s_abort), 1);
    nclk(); nclk();
    check("exh.sticky", longint'(s_exh), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc4_search_scheduler.md
Name: rc4_search_scheduler

Overview:
- Shares the RC4 key space among NUM_CORES identical decrypt cores (each = key-schedule + decrypt + plaintext validity check).
- Hands each idle core the next untried key and collects done/valid results.
- On the first valid plaintext it aborts every core and latches the winning key; if the key space runs out, it reports exhaustion.
- Sits between top-level control (start/status to LEDs/HEX) and the decrypt-core array.

Parameters:
NUM_CORES, 4, number of decrypt cores scheduled (1..16)
KEY_W, 22, key width in bits; key space is 0 .. 2^KEY_W-1

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse; starts or restarts a search from key 0
core_done  input  NUM_CORES  per-core one-cycle pulse: decrypt attempt finished
core_valid  input  NUM_CORES  per-core plaintext-valid flag, qualified by core_done
core_start  output  NUM_CORES  per-core one-cycle launch pulse
core_key  output  NUM_CORES*KEY_W  per-core key; core i occupies bits [i*KEY_W +: KEY_W]
core_abort  output  1  level; forces all cores idle
busy  output  1  search in progress
found  output  1  sticky; valid key located
exhausted  output  1  sticky; key space covered, no valid key
key_found  output  KEY_W  winning key, valid while found=1
keys_tried  output  KEY_W+1  count of completed attempts

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0.
  - next_key (KEY_W+1 bits) = 0; core_busy vector = 0.
  - Reset mid-search abandons the search. No core_abort pulse is produced; the cores share rst.
- States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
- IDLE:
  - start -> RUN; clears next_key, keys_tried, key_found and core_busy.
  - core_done/core_valid are ignored.
- RUN, dispatch:
  - Each cycle, if any core_busy bit is 0 and next_key < 2^KEY_W, pick the lowest-index idle core i.
  - For core i: pulse core_start[i], load core_key[i] <= next_key[KEY_W-1:0], set core_busy[i], next_key += 1.
  - At most one dispatch per cycle.
  - First core_start occurs in the cycle after start is sampled; core_start and core_key update on the same edge.
  - core_key[i] is held stable until core i is dispatched again.
- RUN/DRAIN, completion:
  - Every core_done[i] with core_busy[i]=1 clears core_busy[i]. keys_tried increases by the popcount of such dones; several dones may arrive in the same cycle.
  - core_done on a non-busy core is ignored.
  - A core that completes in cycle t is eligible for dispatch at cycle t+1, never in the same cycle.
- Valid result:
  - If any qualified done has core_valid=1, take the lowest-index such core j.
  - key_found <= core_key[j], found <= 1, state -> FOUND.
  - The dispatch in that cycle is suppressed.
  - This has priority over the exhaustion transitions.
- Keys run out: when next_key reaches 2^KEY_W, RUN -> DRAIN; no further dispatch.
- DRAIN:
  - When core_busy becomes all-zero with no valid result -> EXHAUSTED, exhausted <= 1.
  - If the last done and the last busy-clear coincide with a valid result, go to FOUND.
- FOUND/EXHAUSTED:
  - core_abort=1, busy=0, core_busy cleared.
  - Outputs hold until start, which restarts exactly as from IDLE (found/exhausted cleared on the same edge).
- busy=1 in RUN and DRAIN only.
- start while in RUN/DRAIN is ignored.
- keys_tried saturates at 2^KEY_W; it cannot overflow by construction.

Decomposition:
- Package rc4_sched_pkg:
  - state enum sched_state_t {IDLE, RUN, DRAIN, FOUND, EXHAUSTED}.
  - Default KEY_W constant.
  - KEY_SPACE = 1 << KEY_W helper function.
- Sub-module rc4_sched_pick: parameterised fixed-priority find-first-set. Inputs a NUM_CORES vector; outputs any, one-hot, and index. Instantiated twice: idle-core select and valid-core select.
- Popcount implemented inline as a function in the package.

Test Plan:
- Basic dispatch: NUM_CORES=4, start, no dones -> core_start pulses cores 0,1,2,3 in four consecutive cycles starting 1 cycle after start, with keys 0,1,2,3; no fifth pulse.
- Recycle: core 2 done (invalid) at cycle 10 -> core_start[2] at cycle 11 with key 4; keys_tried=1.
- Simultaneous valid: cores 1 and 3 done in the same cycle, both valid, holding keys 0x00001/0x00003 -> found=1, key_found=0x00001, core_abort=1 next cycle, no further core_start.
- Exhaustion: KEY_W=4, NUM_CORES=2, all dones invalid -> exactly 16 dispatches (keys 0..15), DRAIN until both idle, then exhausted=1, keys_tried=16.
- Spurious and restart: core_done on an idle core -> ignored, keys_tried unchanged. start during RUN -> ignored. start in FOUND -> found=0, core_key[0]=0 dispatched next cycle.
- Reset mid-search: rst=0 during RUN with 3 cores busy -> next edge all outputs 0, state IDLE; later dones ignored until start.
